// File: rtl/mult_ctrl_if.sv
// Handshake and result bus between Decode/hazard logic and the multiply sequencer.
// Decode drives the request side (master); the sequencer drives status and HI/LO (slave).
interface mult_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start_multD;
  logic             signed_op;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             abort;
  logic             mult_busy;
  logic             done;
  logic             hilo_we;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start_multD, signed_op, srcA, srcB, abort,
    input  mult_busy, done, hilo_we, hi, lo
  );

  modport slave (
    input  start_multD, signed_op, srcA, srcB, abort,
    output mult_busy, done, hilo_we, hi, lo
  );
endinterface

// File: rtl/mult_ctrl.sv
// Iterative radix-2 shift-add multiplier for MULT/MULTU.
// It works on operand magnitudes, applies the sign at completion and writes HI/LO once.
module mult_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic       clk,
  input  logic       reset,
  mult_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             stateQ;
  logic [CNT_W-1:0]   cntQ;
  logic [WIDTH-1:0]   mcandQ;
  logic [WIDTH-1:0]   mprQ;
  logic [WIDTH-1:0]   accQ;
  logic [WIDTH-1:0]   hiQ;
  logic [WIDTH-1:0]   loQ;
  logic               negQ;
  logic               doneQ;

  logic               startAccD;
  logic               negD;
  logic [WIDTH-1:0]   absAD;
  logic [WIDTH-1:0]   absBD;
  logic [WIDTH:0]     sumD;
  logic [2*WIDTH-1:0] prodD;
  logic [2*WIDTH-1:0] resultD;

  // A start can only land in IDLE or DONE, and abort always wins over it.
  assign startAccD = bus.start_multD & ~bus.abort & ((stateQ == IDLE) | (stateQ == DONE));
  assign negD      = bus.signed_op & (bus.srcA[WIDTH-1] ^ bus.srcB[WIDTH-1]);
  assign absAD     = (bus.signed_op & bus.srcA[WIDTH-1]) ? -bus.srcA : bus.srcA;
  assign absBD     = (bus.signed_op & bus.srcB[WIDTH-1]) ? -bus.srcB : bus.srcB;

  // One shift-add step; prodD is the full product after the final step.
  assign sumD    = {1'b0, accQ} + {1'b0, mcandQ & {WIDTH{mprQ[0]}}};
  assign prodD   = {sumD, mprQ[WIDTH-1:1]};
  assign resultD = negQ ? -prodD : prodD;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ <= IDLE;
      cntQ   <= '0;
      mcandQ <= '0;
      mprQ   <= '0;
      accQ   <= '0;
      hiQ    <= '0;
      loQ    <= '0;
      negQ   <= 1'b0;
      doneQ  <= 1'b0;
    end else begin
      doneQ <= 1'b0;
      case (stateQ)
        IDLE, DONE: begin
          if (startAccD) begin
            mcandQ <= absAD;
            mprQ   <= absBD;
            accQ   <= '0;
            negQ   <= negD;
            cntQ   <= CNT_W'(WIDTH - 1);
            stateQ <= RUN;
          end else begin
            stateQ <= IDLE;
          end
        end
        RUN: begin
          if (bus.abort) begin
            stateQ <= IDLE;
          end else begin
            accQ <= sumD[WIDTH:1];
            mprQ <= {sumD[0], mprQ[WIDTH-1:1]};
            if (cntQ == '0) begin
              {hiQ, loQ} <= resultD;
              doneQ      <= 1'b1;
              stateQ     <= DONE;
            end else begin
              cntQ <= cntQ - CNT_W'(1);
            end
          end
        end
        default: stateQ <= IDLE;
      endcase
    end
  end

  // The stall must rise in the very cycle a start is accepted, so it stays combinational.
  assign bus.mult_busy = (stateQ == RUN) | startAccD;
  assign bus.done      = doneQ;
  assign bus.hilo_we   = doneQ;
  assign bus.hi        = hiQ;
  assign bus.lo        = loQ;

endmodule

// File: tb/tb_mult_ctrl.sv
// Self-checking bench for mult_ctrl: vector table and random operands through a result
// scoreboard, plus hand-written latency, back-to-back, abort and reset sequences.
module tb_mult_ctrl;
  localparam int WIDTH = 32;
  localparam int CNT_W = 6;
  localparam int NVEC  = 11;

  typedef struct {
    logic             signedOp;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] expHi;
    logic [WIDTH-1:0] expLo;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int cmpCount = 0;
  int failCount = 0;
  logic [2*WIDTH-1:0] sbQ[$];

  mult_ctrl_if #(.WIDTH(WIDTH)) bus();

  mult_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] refMul(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    if (s) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
    end else begin
      sa = {32'h0, a};
      sb = {32'h0, b};
    end
    return sa * sb;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    cmpCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic [31:0] a, input logic [31:0] b,
                               input logic [63:0] expected);
    bus.signed_op   = s;
    bus.srcA        = a;
    bus.srcB        = b;
    bus.start_multD = 1'b1;
    sbQ.push_back(expected);
    nextCycle();
    bus.start_multD = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (sbQ.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    cmpCount++;
    if (sbQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL drain timeout: %0d results outstanding, required 0", sbQ.size());
      sbQ.delete();
    end
  endtask

  // Scoreboard side: every completion pulse must match the oldest outstanding result.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      checkOutput("hilo_we at done", 64'(bus.hilo_we), 64'd1);
      if (sbQ.size() == 0) begin
        cmpCount++;
        failCount++;
        $display("[TB] FAIL unexpected done: hi=0x%0h lo=0x%0h, required no completion", bus.hi, bus.lo);
      end else begin
        checkOutput("product", {bus.hi, bus.lo}, sbQ.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[NVEC];
    logic s;
    logic [31:0] ra;
    logic [31:0] rb;

    vecs[0]  = '{1'b0, 32'd3,        32'd5,        32'h00000000, 32'h0000000F};
    vecs[1]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{1'b1, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[3]  = '{1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[4]  = '{1'b1, 32'h80000000, 32'd1,        32'hFFFFFFFF, 32'h80000000};
    vecs[5]  = '{1'b1, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[6]  = '{1'b0, 32'd0,        32'h12345678, 32'h00000000, 32'h00000000};
    vecs[7]  = '{1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
    vecs[8]  = '{1'b0, 32'h80000000, 32'd2,        32'h00000001, 32'h00000000};
    vecs[9]  = '{1'b0, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF};
    vecs[10] = '{1'b1, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'h00000000, 32'h0000001E};

    reset           = 1'b1;
    bus.start_multD = 1'b0;
    bus.signed_op   = 1'b0;
    bus.srcA        = '0;
    bus.srcB        = '0;
    bus.abort       = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset busy", 64'(bus.mult_busy), 64'd0);
    checkOutput("reset done", 64'(bus.done), 64'd0);
    checkOutput("reset hilo_we", 64'(bus.hilo_we), 64'd0);
    checkOutput("reset hilo", {bus.hi, bus.lo}, 64'd0);
    reset = 1'b0;
    nextCycle();

    $display("[TB] latency and busy profile, unsigned 3*5");
    bus.signed_op   = 1'b0;
    bus.srcA        = 32'd3;
    bus.srcB        = 32'd5;
    bus.start_multD = 1'b1;
    sbQ.push_back(64'h0F);
    @(negedge clk);
    checkOutput("busy c0", 64'(bus.mult_busy), 64'd1);
    for (int cyc = 1; cyc <= 33; cyc++) begin
      nextCycle();
      bus.start_multD = 1'b0;
      @(negedge clk);
      checkOutput($sformatf("busy c%0d", cyc), 64'(bus.mult_busy), 64'(cyc <= 32));
      checkOutput($sformatf("done c%0d", cyc), 64'(bus.done), 64'(cyc == 33));
    end
    nextCycle();

    $display("[TB] vector table");
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].signedOp, vecs[i].a, vecs[i].b, {vecs[i].expHi, vecs[i].expLo});
      waitDrain(40);
    end

    $display("[TB] random operands");
    for (int i = 0; i < 8; i++) begin
      s  = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      applyStimulus(s, ra, rb, refMul(s, ra, rb));
      waitDrain(40);
    end

    $display("[TB] back-to-back 2*2 then 7*6");
    bus.signed_op   = 1'b0;
    bus.srcA        = 32'd2;
    bus.srcB        = 32'd2;
    bus.start_multD = 1'b1;
    sbQ.push_back(64'd4);
    @(negedge clk);
    checkOutput("b2b busy c0", 64'(bus.mult_busy), 64'd1);
    for (int cyc = 1; cyc <= 66; cyc++) begin
      nextCycle();
      if (cyc == 1 || cyc == 34) bus.start_multD = 1'b0;
      if (cyc == 33) begin
        bus.srcA        = 32'd7;
        bus.srcB        = 32'd6;
        bus.start_multD = 1'b1;
        sbQ.push_back(64'd42);
      end
      @(negedge clk);
      checkOutput($sformatf("b2b busy c%0d", cyc), 64'(bus.mult_busy), 64'(cyc != 66));
      checkOutput($sformatf("b2b done c%0d", cyc), 64'(bus.done), 64'(cyc == 33 || cyc == 66));
    end
    nextCycle();
    checkOutput("b2b drained", 64'(sbQ.size()), 64'd0);

    $display("[TB] abort in RUN at cycle 10");
    bus.srcA        = 32'd9;
    bus.srcB        = 32'd9;
    bus.start_multD = 1'b1;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      nextCycle();
      if (cyc == 1) bus.start_multD = 1'b0;
      if (cyc == 10) bus.abort = 1'b1;
      if (cyc == 11) bus.abort = 1'b0;
      @(negedge clk);
      checkOutput($sformatf("abort busy c%0d", cyc), 64'(bus.mult_busy), 64'(cyc <= 10));
      checkOutput($sformatf("abort done c%0d", cyc), 64'(bus.done), 64'd0);
    end
    checkOutput("abort hilo kept", {bus.hi, bus.lo}, 64'd42);

    $display("[TB] start with abort in IDLE");
    nextCycle();
    bus.srcA        = 32'd5;
    bus.srcB        = 32'd5;
    bus.start_multD = 1'b1;
    bus.abort       = 1'b1;
    @(negedge clk);
    checkOutput("idle abort busy", 64'(bus.mult_busy), 64'd0);
    nextCycle();
    bus.start_multD = 1'b0;
    bus.abort       = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc % 10 == 0) checkOutput($sformatf("idle abort busy +%0d", cyc), 64'(bus.mult_busy), 64'd0);
    end
    checkOutput("idle abort hilo kept", {bus.hi, bus.lo}, 64'd42);

    $display("[TB] abort in DONE blocks a same-cycle start");
    nextCycle();
    bus.srcA        = 32'd3;
    bus.srcB        = 32'd3;
    bus.start_multD = 1'b1;
    sbQ.push_back(64'd9);
    for (int cyc = 1; cyc <= 33; cyc++) begin
      nextCycle();
      bus.start_multD = 1'b0;
      if (cyc == 33) begin
        bus.srcA        = 32'd4;
        bus.srcB        = 32'd4;
        bus.start_multD = 1'b1;
        bus.abort       = 1'b1;
      end
    end
    @(negedge clk);
    checkOutput("done-abort done", 64'(bus.done), 64'd1);
    checkOutput("done-abort busy", 64'(bus.mult_busy), 64'd0);
    nextCycle();
    bus.start_multD = 1'b0;
    bus.abort       = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc % 10 == 0) checkOutput($sformatf("done-abort busy +%0d", cyc), 64'(bus.mult_busy), 64'd0);
    end
    checkOutput("done-abort hilo", {bus.hi, bus.lo}, 64'd9);

    $display("[TB] asynchronous reset at cycle 15 of a run");
    nextCycle();
    bus.srcA        = 32'h1234;
    bus.srcB        = 32'h10;
    bus.start_multD = 1'b1;
    for (int cyc = 1; cyc <= 15; cyc++) begin
      nextCycle();
      bus.start_multD = 1'b0;
    end
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async reset busy", 64'(bus.mult_busy), 64'd0);
    checkOutput("async reset done", 64'(bus.done), 64'd0);
    checkOutput("async reset hilo_we", 64'(bus.hilo_we), 64'd0);
    checkOutput("async reset hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc % 10 == 0) checkOutput($sformatf("post-reset busy +%0d", cyc), 64'(bus.mult_busy), 64'd0);
    end
    nextCycle();
    applyStimulus(1'b1, 32'hFFFFFFF9, 32'd6, refMul(1'b1, 32'hFFFFFFF9, 32'd6));
    waitDrain(40);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
    $finish;
  end
endmodule

// File: doc/mult_ctrl.md
Name: mult_ctrl

Overview:
- Multi-cycle multiply sequencer for the 5-stage MIPS core. It serves MULT and MULTU.
- Accepts a start pulse from Decode, runs an iterative radix-2 shift-add on latched operands, and writes HI/LO once at completion.
- Drives the stall request that the hazard unit folds into StallF while a multiply is in flight.

Parameters:
- WIDTH, 32, operand width in bits. The product is 2*WIDTH bits, split into HI and LO.
- CNT_W, 6, counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high. Forces IDLE and clears all registers.
- start_multD  in  1  one-cycle request from Decode to begin a multiply.
- signed_op  in  1  1 = MULT (two's complement), 0 = MULTU. Sampled together with start.
- srcA  in  WIDTH  multiplicand. Sampled with start.
- srcB  in  WIDTH  multiplier. Sampled with start.
- abort  in  1  synchronous cancel, for example on a pipeline flush.
- mult_busy  out  1  stall request to the hazard unit.
- done  out  1  one-cycle completion pulse.
- hilo_we  out  1  HI/LO write enable. Equal to done.
- hi  out  WIDTH  upper half of the last completed product.
- lo  out  WIDTH  lower half of the last completed product.

Behaviour:
- Reset values: state = IDLE; mult_busy = 0; done = 0; hilo_we = 0; hi = 0; lo = 0; counter = 0; operand and accumulator registers = 0. Reset asserted mid-RUN discards the operation with no write.
- States:
  - IDLE: a start is accepted when start_multD = 1 and abort = 0. On acceptance, latch |srcA|, |srcB|, and neg = signed_op & (srcA[MSB] ^ srcB[MSB]); clear the accumulator; set counter = WIDTH-1; next state RUN.
  - RUN: each cycle, if the multiplier LSB = 1, add the multiplicand into the upper accumulator half, then shift the {accumulator, multiplier} pair right by 1 with carry. On counter == 0, next state DONE; otherwise decrement the counter.
  - DONE: register the final product into hi/lo, two's-complement-negated over all 2*WIDTH bits when neg = 1. done = hilo_we = 1 for exactly this cycle. Next state IDLE, or RUN if a new start is accepted in this cycle.
- Signed magnitude: the magnitude of the most-negative value is taken as unsigned 2^(WIDTH-1). -2^31 * -2^31 = 0x4000000000000000.
- In unsigned mode, MSBs are not treated as signs and neg = 0.
- Latency: a start sampled in cycle c0 puts RUN in cycles c1..cWIDTH and DONE in cycle c(WIDTH+1). At WIDTH = 32, done appears 33 cycles after start.
- hi and lo are registered outputs. They update only on entry to DONE and hold until the next completion.
- mult_busy is combinational: (state == RUN) | (state == IDLE & accepted start) | (state == DONE & accepted start). It is low in a DONE cycle that has no new start.
- start_multD in RUN is ignored with no queueing. Decode must hold the instruction under stall.
- Start in DONE is accepted (back-to-back). The old result is still written in that cycle and the new operands are latched.
- abort in RUN: next state IDLE; no done; hi and lo unchanged.
- abort in IDLE has priority over start: the start is dropped.
- abort in DONE does not suppress the current write, but it blocks a same-cycle start.

Test Plan:
- Unsigned 3*5: start cycle 0 → done = hilo_we = 1 at cycle 33, hi = 0x00000000, lo = 0x0000000F; mult_busy = 1 in cycles 0..32 and 0 at cycle 33.
- Unsigned 0xFFFFFFFF * 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001.
- Signed cases:
  - -1 * 1 → hi = 0xFFFFFFFF, lo = 0xFFFFFFFF.
  - 0x80000000 * 0x80000000 → hi = 0x40000000, lo = 0.
  - 0x80000000 * 1 → hi = 0xFFFFFFFF, lo = 0x80000000.
- Back-to-back: second start (7*6) in the DONE cycle of the first (2*2) → lo = 4 at cycle 33, lo = 42 at cycle 66; mult_busy remains 1 through cycle 33.
- Abort at cycle 10 of a run → no done pulse; hi and lo retain their previous values; mult_busy = 0 from cycle 11. A start in the same cycle as abort in IDLE is dropped.
- Reset asserted at cycle 15 of a run, asynchronously between clock edges → all outputs 0 immediately; no done after release; a new start after release completes normally.
